// File: rtl/sens_power_return_fmt.sv
// ----------------------------------------------------------------------------
// sens_power_return_fmt
//   Captures each converted power value into a per-channel slot and, on
//   request, streams one return frame of 16-bit words over valid/ready:
//   header {8'hA5, fresh mask}, NCH data words {fresh, 5'b0, value}, checksum.
//
// Ports
//   i_clk         clock, all logic on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_pwr_dout    converted power value (10 bits)
//   i_calc_done   1-cycle pulse, i_pwr_dout/i_ch_sel valid this cycle
//   i_ch_sel      channel of current conversion (>= NCH is ignored)
//   i_frame_req   1-cycle pulse requesting a return frame
//   o_ret_data    frame word
//   o_ret_valid   o_ret_data valid
//   i_ret_ready   consumer accepts word when valid & ready
//   o_frame_busy  high from request acceptance until checksum accepted
//   o_ovr_err     1-cycle pulse: capture overwrote an unsent fresh value
//   o_req_drop    1-cycle pulse: request ignored because a frame is in flight
// ----------------------------------------------------------------------------
module sens_power_return_fmt #(
    parameter int NCH  = 4,
    parameter int CH_W = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [9:0]      i_pwr_dout,
    input  logic            i_calc_done,
    input  logic [CH_W-1:0] i_ch_sel,
    input  logic            i_frame_req,
    output logic [15:0]     o_ret_data,
    output logic            o_ret_valid,
    input  logic            i_ret_ready,
    output logic            o_frame_busy,
    output logic            o_ovr_err,
    output logic            o_req_drop
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StSum} state_t;

    state_t           r_state;
    logic [9:0]       r_slot    [NCH];
    logic [9:0]       r_sh_slot [NCH];
    logic [NCH-1:0]   r_fresh;
    logic [NCH-1:0]   r_sh_fresh;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_sum;
    logic [15:0]      r_ret_data;
    logic             r_ret_valid;
    logic             r_busy;
    logic             r_ovr;
    logic             r_drop;

    logic             w_cap_ok;
    logic [IDX_W-1:0] w_cap_ch;
    logic [NCH-1:0]   w_fresh_set;
    logic [NCH-1:0]   w_fresh_clr;
    logic             w_req_ok;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       w_mask8;
    logic [15:0]      w_word_cur;
    logic [15:0]      w_word_nxt;

    always_comb begin
        w_cap_ok    = i_calc_done && (int'(i_ch_sel) < NCH);
        w_cap_ch    = i_ch_sel[IDX_W-1:0];
        w_fresh_set = w_cap_ok ? (NCH'(1) << w_cap_ch) : '0;
        w_req_ok    = i_frame_req && (r_state == StIdle);
        // A same-cycle capture re-sets its bit after the clear, so it stays fresh
        w_fresh_clr = w_req_ok ? '1 : '0;
        w_accept    = r_ret_valid && i_ret_ready;
        w_idx_nxt   = r_idx + 1'b1;
        w_mask8     = 8'(r_sh_fresh);
        w_word_cur  = {r_sh_fresh[r_idx], 5'b0, r_sh_slot[r_idx]};
        w_word_nxt  = {r_sh_fresh[w_idx_nxt], 5'b0, r_sh_slot[w_idx_nxt]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            for (int i = 0; i < NCH; i++) begin
                r_slot[i]    <= '0;
                r_sh_slot[i] <= '0;
            end
            r_fresh     <= '0;
            r_sh_fresh  <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_ret_data  <= '0;
            r_ret_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ovr       <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            // Capture path runs regardless of frame state
            r_ovr   <= w_cap_ok && r_fresh[w_cap_ch];
            r_drop  <= i_frame_req && (r_state != StIdle);
            if (w_cap_ok) begin
                r_slot[w_cap_ch] <= i_pwr_dout;
            end
            r_fresh <= (r_fresh & ~w_fresh_clr) | w_fresh_set;

            unique case (r_state)
                StIdle: begin
                    if (i_frame_req) begin
                        // Nonblocking reads: snapshot sees pre-capture slot values
                        r_sh_slot  <= r_slot;
                        r_sh_fresh <= r_fresh;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= StHdr;
                    end
                end
                StHdr: begin
                    if (!r_ret_valid) begin
                        r_ret_data  <= {8'hA5, w_mask8};
                        r_ret_valid <= 1'b1;
                    end else if (i_ret_ready) begin
                        r_sum      <= r_sum + r_ret_data;
                        r_ret_data <= w_word_cur;
                        r_state    <= StData;
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_sum <= r_sum + r_ret_data;
                        if (r_idx == LastIdx) begin
                            // Checksum includes the word being accepted now
                            r_ret_data <= r_sum + r_ret_data;
                            r_state    <= StSum;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_ret_data <= w_word_nxt;
                        end
                    end
                end
                StSum: begin
                    if (w_accept) begin
                        r_ret_data  <= '0;
                        r_ret_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ret_data   = r_ret_data;
    assign o_ret_valid  = r_ret_valid;
    assign o_frame_busy = r_busy;
    assign o_ovr_err    = r_ovr;
    assign o_req_drop   = r_drop;

endmodule

// File: tb/tb_sens_power_return_fmt.sv
module tb_sens_power_return_fmt;

    localparam int NCH = 4;
    localparam int NW  = NCH + 2;

    logic        i_clk;
    logic        i_rst_n;
    logic [9:0]  i_pwr_dout;
    logic        i_calc_done;
    logic [2:0]  i_ch_sel;
    logic        i_frame_req;
    logic [15:0] o_ret_data;
    logic        o_ret_valid;
    logic        i_ret_ready;
    logic        o_frame_busy;
    logic        o_ovr_err;
    logic        o_req_drop;

    sens_power_return_fmt #(.NCH(NCH), .CH_W(3)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pwr_dout  (i_pwr_dout),
        .i_calc_done (i_calc_done),
        .i_ch_sel    (i_ch_sel),
        .i_frame_req (i_frame_req),
        .o_ret_data  (o_ret_data),
        .o_ret_valid (o_ret_valid),
        .i_ret_ready (i_ret_ready),
        .o_frame_busy(o_frame_busy),
        .o_ovr_err   (o_ovr_err),
        .o_req_drop  (o_req_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: channel values and freshness
    logic [9:0]  m_slot  [NCH];
    bit          m_fresh [NCH];
    logic [15:0] exp_w   [0:7];
    logic [15:0] got_w   [0:7];
    int          got_n, got_wait, got_bubbles;
    bit          got_stable, got_busy, got_drop;

    task automatic cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_slot[i]  = '0;
            m_fresh[i] = 1'b0;
        end
    endfunction

    function automatic bit m_capture(input int ch, input logic [9:0] val);
        bit o;
        o = 1'b0;
        if (ch < NCH) begin
            o           = m_fresh[ch];
            m_slot[ch]  = val;
            m_fresh[ch] = 1'b1;
        end
        return o;
    endfunction

    // Frame the model would send right now
    function automatic void build_exp();
        int         s;
        logic [7:0] mask;
        mask = '0;
        for (int i = 0; i < NCH; i++) mask[i] = m_fresh[i];
        exp_w[0] = {8'hA5, mask};
        s = int'(exp_w[0]);
        for (int i = 0; i < NCH; i++) begin
            exp_w[i+1] = (m_fresh[i] ? 16'h8000 : 16'h0000) + 16'(m_slot[i]);
            s += int'(exp_w[i+1]);
        end
        s = s % 65536;
        exp_w[NCH+1] = s[15:0];
        for (int i = NW; i < 8; i++) exp_w[i] = '0;
    endfunction

    task automatic capture(input int ch, input logic [9:0] val, output bit ovr_got,
                           output bit ovr_exp);
        ovr_exp     = m_capture(ch, val);
        i_calc_done = 1'b1;
        i_ch_sel    = 3'(ch);
        i_pwr_dout  = val;
        cycle();
        ovr_got     = o_ovr_err;
        i_calc_done = 1'b0;
    endtask

    task automatic send_req(input bit cap, input int ch, input logic [9:0] val);
        bit unused;
        build_exp();
        for (int i = 0; i < NCH; i++) m_fresh[i] = 1'b0;
        if (cap) begin
            unused      = m_capture(ch, val);
            i_calc_done = 1'b1;
            i_ch_sel    = 3'(ch);
            i_pwr_dout  = val;
        end
        i_frame_req = 1'b1;
        cycle();
        i_frame_req = 1'b0;
        i_calc_done = 1'b0;
    endtask

    // mode 0: ready=1, 1: toggle, 2: random. inject_at: word count at which to
    // pulse frame_req mid-frame (-1 none).
    task automatic get_frame(input int mode, input int inject_at);
        bit          r, first, prev_stall, injected, pend;
        logic [15:0] prev_data;
        got_n = 0; got_wait = 0; got_bubbles = 0;
        got_stable = 1'b1; got_busy = 1'b1; got_drop = 1'b0;
        first = 0; prev_stall = 0; injected = 0; pend = 0; prev_data = '0;
        for (int c = 0; c < 200 && got_n < NW; c++) begin
            if (pend) begin
                got_drop = o_req_drop;
                pend = 0;
            end
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            i_ret_ready = r;
            if (inject_at >= 0 && !injected && first && got_n == inject_at) begin
                i_frame_req = 1'b1;
                injected = 1;
                pend = 1;
            end
            if (!o_frame_busy) got_busy = 1'b0;
            if (o_ret_valid) begin
                first = 1;
                if (prev_stall && o_ret_data !== prev_data) got_stable = 1'b0;
                if (r) begin
                    got_w[got_n] = o_ret_data;
                    got_n++;
                end
                prev_stall = !r;
                prev_data  = o_ret_data;
            end else begin
                if (prev_stall) got_stable = 1'b0;
                if (first) got_bubbles++;
                else got_wait++;
                prev_stall = 0;
            end
            cycle();
            i_frame_req = 1'b0;
        end
        if (pend) got_drop = o_req_drop;
        i_ret_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (o_ret_valid !== 1'b0 || o_frame_busy !== 1'b0 || o_ovr_err !== 1'b0 ||
            o_req_drop !== 1'b0 || o_ret_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b o=%b d=%b data=%h, want all 0",
                     o_ret_valid, o_frame_busy, o_ovr_err, o_req_drop, o_ret_data);
        end
    endtask

    task automatic test_basic();
        logic [15:0] gold [0:5];
        bit og, oe;
        gold = '{16'hA507, 16'h83FF, 16'h8000, 16'h8200, 16'h0000, 16'h2B06};
        capture(0, 10'h3FF, og, oe);
        capture(1, 10'h000, og, oe);
        capture(2, 10'h200, og, oe);
        send_req(0, 0, '0);
        n_tests++;
        if (o_ret_valid !== 1'b0 || o_frame_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b busy=%b one edge after req, want 0/1",
                     o_ret_valid, o_frame_busy);
        end
        get_frame(0, -1);
        n_tests++;
        if (got_n !== NW || got_wait !== 1 || got_bubbles !== 0) begin
            n_fail++;
            $display("FAIL basic_timing: got words=%0d wait=%0d bubbles=%0d, want %0d/1/0",
                     got_n, got_wait, got_bubbles, NW);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== gold[i] || got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h, want %h", i, got_w[i], gold[i]);
            end
        end
        n_tests++;
        if (o_ret_valid !== 1'b0 || o_frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got valid=%b busy=%b after checksum, want 0/0",
                     o_ret_valid, o_frame_busy);
        end
    endtask

    task automatic test_stall();
        bit og, oe;
        capture(0, 10'h3FF, og, oe);
        capture(1, 10'h000, og, oe);
        capture(2, 10'h200, og, oe);
        send_req(0, 0, '0);
        get_frame(1, -1);
        n_tests++;
        if (got_n !== NW || !got_stable || !got_busy) begin
            n_fail++;
            $display("FAIL stall_hold: got words=%0d stable=%b busy=%b, want %0d/1/1",
                     got_n, got_stable, got_busy, NW);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_ovr();
        bit og1, oe1, og2, oe2;
        capture(1, 10'h010, og1, oe1);
        capture(1, 10'h020, og2, oe2);
        n_tests++;
        if (og1 !== 1'b0 || og2 !== 1'b1 || oe2 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %b,%b, want 0,1", og1, og2);
        end
        cycle();
        n_tests++;
        if (o_ovr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_width: got ovr_err=%b second cycle, want 0", o_ovr_err);
        end
        send_req(0, 0, '0);
        get_frame(0, -1);
        n_tests++;
        if (got_w[2] !== 16'h8020 || got_w[0] !== 16'hA502) begin
            n_fail++;
            $display("FAIL ovr_data1: got hdr=%h d1=%h, want A502/8020", got_w[0], got_w[2]);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL ovr_f1_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
        // Back-to-back request with no new captures
        send_req(0, 0, '0);
        get_frame(0, -1);
        n_tests++;
        if (got_n !== NW || got_w[0] !== 16'hA500 || got_w[1][15] || got_w[2][15] ||
            got_w[3][15] || got_w[4][15]) begin
            n_fail++;
            $display("FAIL ovr_f2_stale: got n=%0d hdr=%h, want A500 and no fresh bits",
                     got_n, got_w[0]);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL ovr_f2_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        send_req(1, 3, 10'h155);
        get_frame(0, -1);
        n_tests++;
        if (got_w[4] !== 16'h0000 || got_w[4] !== exp_w[4]) begin
            n_fail++;
            $display("FAIL same_old: got d3=%h, want 0000", got_w[4]);
        end
        send_req(0, 0, '0);
        get_frame(0, -1);
        n_tests++;
        if (got_w[0] !== 16'hA508 || got_w[4] !== 16'h8155) begin
            n_fail++;
            $display("FAIL same_next: got hdr=%h d3=%h, want A508/8155", got_w[0], got_w[4]);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL same_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_drop();
        bit og, oe;
        capture(5, 10'h3AA, og, oe);
        n_tests++;
        if (og !== 1'b0) begin
            n_fail++;
            $display("FAIL range_ovr: got ovr_err=%b for ch_sel=5, want 0", og);
        end
        send_req(0, 0, '0);
        get_frame(2, 2);
        n_tests++;
        if (got_drop !== 1'b1 || got_n !== NW) begin
            n_fail++;
            $display("FAIL drop_pulse: got req_drop=%b words=%0d, want 1/%0d",
                     got_drop, got_n, NW);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL drop_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if (o_frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_nostart: got busy=%b after frame, want 0", o_frame_busy);
        end
    endtask

    task automatic test_async_reset();
        int c;
        bit og, oe;
        capture(2, 10'h0AB, og, oe);
        send_req(0, 0, '0);
        c = 0;
        while (!o_ret_valid && c < 10) begin
            cycle();
            c++;
        end
        i_ret_ready = 1'b1;
        cycle();
        cycle();
        i_ret_ready = 1'b0;
        n_tests++;
        if (o_ret_valid !== 1'b1 || o_frame_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got valid=%b busy=%b mid-frame, want 1/1",
                     o_ret_valid, o_frame_busy);
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_ret_valid !== 1'b0 || o_frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b busy=%b before clk, want 0/0",
                     o_ret_valid, o_frame_busy);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_reset();
        cycle();
        n_tests++;
        if (o_ret_valid !== 1'b0 || o_frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_noresume: got valid=%b busy=%b, want 0/0",
                     o_ret_valid, o_frame_busy);
        end
        send_req(0, 0, '0);
        get_frame(0, -1);
        n_tests++;
        if (got_n !== NW || got_w[0] !== 16'hA500 || got_w[1] !== 16'h0000 ||
            got_w[2] !== 16'h0000 || got_w[3] !== 16'h0000 || got_w[4] !== 16'h0000 ||
            got_w[5] !== 16'hA500) begin
            n_fail++;
            $display("FAIL rst_frame: got n=%0d %h %h %h %h %h %h, want A500 0 0 0 0 A500",
                     got_n, got_w[0], got_w[1], got_w[2], got_w[3], got_w[4], got_w[5]);
        end
    endtask

    task automatic test_random();
        bit og, oe;
        int k, ch;
        for (int it = 0; it < 15; it++) begin
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                ch = $urandom_range(0, 5);
                capture(ch, 10'($urandom), og, oe);
                n_tests++;
                if (og !== oe) begin
                    n_fail++;
                    $display("FAIL rand_ovr it%0d ch%0d: got %b, want %b", it, ch, og, oe);
                end
            end
            if ($urandom_range(0, 3) == 0)
                send_req(1, $urandom_range(0, 5), 10'($urandom));
            else
                send_req(0, 0, '0);
            get_frame(2, -1);
            n_tests++;
            if (got_n !== NW || !got_stable) begin
                n_fail++;
                $display("FAIL rand_hs it%0d: got words=%0d stable=%b, want %0d/1",
                         it, got_n, got_stable, NW);
            end
            for (int i = 0; i < NW; i++) begin
                n_tests++;
                if (got_w[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL rand_word it%0d w%0d: got %h, want %h",
                             it, i, got_w[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_pwr_dout  = '0;
        i_calc_done = 1'b0;
        i_ch_sel    = '0;
        i_frame_req = 1'b0;
        i_ret_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge i_clk);
        test_reset();
        i_rst_n = 1'b1;
        cycle();
        test_basic();
        test_stall();
        test_ovr();
        test_same_cycle();
        test_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
